// File: rtl/ext_unit_skid.sv
// Pipelined immediate-extension stage (ID -> EX) with a 2-entry skid buffer.
// The main entry drives out_*; the skid entry catches one result while downstream stalls.
module ext_unit_skid #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_bad_op,
  output logic             err_sticky
);

  localparam int PAD_W = OUT_W - IN_W;

  localparam logic [2:0] OP_ZERO    = 3'b000;
  localparam logic [2:0] OP_SIGNED  = 3'b001;
  localparam logic [2:0] OP_HIGHPOS = 3'b010;
  localparam logic [2:0] OP_SHL2    = 3'b011;

  logic             main_valid;
  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_bad_op;

  logic [OUT_W-1:0] sext_data;
  logic [OUT_W-1:0] new_data;
  logic             new_bad_op;
  logic             accept;
  logic             pop;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its payload stable until that edge, ready never depends on valid.
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign accept    = in_valid && in_ready;
  assign pop       = main_valid && out_ready;

  always_comb begin
    sext_data  = {{PAD_W{in_data[IN_W-1]}}, in_data};
    new_data   = '0;
    new_bad_op = 1'b0;
    case (in_op)
      OP_ZERO:    new_data = {{PAD_W{1'b0}}, in_data};
      OP_SIGNED:  new_data = sext_data;
      OP_HIGHPOS: new_data = {in_data, {PAD_W{1'b0}}};
      OP_SHL2:    new_data = sext_data << 2;
      default:    new_bad_op = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
      out_bad_op  <= 1'b0;
      skid_data   <= '0;
      skid_tag    <= '0;
      skid_bad_op <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      // A squashed accept still records that an illegal op reached this stage.
      if (accept && new_bad_op)
        err_sticky <= 1'b1;

      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (skid_valid && pop) begin
        out_data   <= skid_data;
        out_tag    <= skid_tag;
        out_bad_op <= skid_bad_op;
        skid_valid <= 1'b0;
      end else if (accept && (!main_valid || pop)) begin
        out_data   <= new_data;
        out_tag    <= in_tag;
        out_bad_op <= new_bad_op;
        main_valid <= 1'b1;
      end else if (accept) begin
        skid_data   <= new_data;
        skid_tag    <= in_tag;
        skid_bad_op <= new_bad_op;
        skid_valid  <= 1'b1;
      end else if (pop) begin
        main_valid <= 1'b0;
      end
    end
  end

endmodule
